// File: rtl/hpdl_pkg.sv
// hpdl_pkg: shared constants, writer FSM states and the character sanitiser
// for the multi-chip HPDL-1414 display controller.
package hpdl_pkg;

  localparam int         CHARS_PER_DISPLAY = 4;
  localparam logic [6:0] BLANK_CHAR        = 7'h20;
  localparam logic [7:0] CHAR_MIN          = 8'h20;
  localparam logic [7:0] CHAR_MAX          = 8'h5F;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } wr_state_t;

  // Optionally fold lower case onto upper case, then blank anything the
  // HPDL-1414 character ROM cannot display.
  function automatic logic [6:0] hpdl_sanitize(input logic [7:0] ch, input logic fold);
    logic [7:0] c;
    c = (fold && ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    return (c >= CHAR_MIN && c <= CHAR_MAX) ? c[6:0] : BLANK_CHAR;
  endfunction

endpackage

// File: rtl/hpdl_display_ctrl_strobe_timer.sv
// hpdl_strobe_timer: loadable down-counter that times the setup, strobe and
// hold phases of one character write.
module hpdl_strobe_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Load phase length minus one on entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hpdl_display_ctrl.sv
// hpdl_display_ctrl: shadow buffer with per-character dirty bits feeding a
// scanning writer that strobes changed characters into NUM_DISPLAYS
// HPDL-1414 chips over a shared data/address bus.
module hpdl_display_ctrl
  import hpdl_pkg::*;
#(
  parameter int NUM_DISPLAYS = 4,
  parameter int T_SETUP      = 2,
  parameter int T_WR         = 4,
  parameter int T_HOLD       = 2,
  parameter int REFRESH      = 0,
  parameter int FOLD_CASE    = 1,
  localparam int NUM_CHARS   = CHARS_PER_DISPLAY * NUM_DISPLAYS,
  localparam int AW          = $clog2(NUM_CHARS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    wr_use_cursor,
  input  logic                    clr,
  output logic                    busy,
  output logic [6:0]              hpdl_d,
  output logic [1:0]              hpdl_a,
  output logic [NUM_DISPLAYS-1:0] hpdl_wr_n
);

  localparam int CW    = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
  localparam int T_MAX = (T_SETUP > T_WR) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                          : ((T_WR > T_HOLD) ? T_WR : T_HOLD);
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [AW-1:0] LAST = AW'(NUM_CHARS - 1);

  wr_state_t             state_q, state_next;
  logic [6:0]            buffer [NUM_CHARS];
  logic [NUM_CHARS-1:0]  dirty;
  logic [AW-1:0]         cursor, ptr, wr_idx;
  logic [CW-1:0]         chip;
  logic                  take, advance, wr_fire, wr_in_range;
  logic                  tmr_load, tmr_done;
  logic [TW-1:0]         tmr_value;
  logic [6:0]            wr_char;

  assign wr_ready    = ~clr;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_idx      = wr_use_cursor ? cursor : wr_addr;
  assign wr_in_range = {1'b0, wr_idx} < (AW + 1)'(NUM_CHARS);
  assign wr_char     = hpdl_sanitize(wr_data, FOLD_CASE != 0);
  assign busy        = (|dirty) || (state_q != IDLE) || (REFRESH != 0);

  hpdl_strobe_timer #(.W(TW)) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .load      (tmr_load),
    .load_value(tmr_value),
    .done      (tmr_done)
  );

  // Writer state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // Writer next-state: pick up a dirty char in IDLE, then walk the timed phases.
  always_comb begin
    state_next = state_q;
    take       = 1'b0;
    advance    = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state_q)
      IDLE: begin
        if (dirty[ptr] || REFRESH != 0) begin
          take       = 1'b1;
          state_next = SETUP;
          tmr_load   = 1'b1;
          tmr_value  = TW'(T_SETUP - 1);
        end else begin
          advance = 1'b1;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_next = STROBE;
          tmr_load   = 1'b1;
          tmr_value  = TW'(T_WR - 1);
        end
      end
      STROBE: begin
        if (tmr_done) begin
          state_next = HOLD;
          tmr_load   = 1'b1;
          tmr_value  = TW'(T_HOLD - 1);
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_next = IDLE;
          advance    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow buffer, dirty bits and cursor; host writes win over the writer's clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CHARS; i++) buffer[i] <= BLANK_CHAR;
      dirty  <= '1;
      cursor <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CHARS; i++) buffer[i] <= BLANK_CHAR;
      dirty  <= '1;
      cursor <= '0;
    end else begin
      if (take) dirty[ptr] <= 1'b0;
      if (wr_fire && wr_in_range) begin
        buffer[wr_idx] <= wr_char;
        dirty[wr_idx]  <= 1'b1;
      end
      if (wr_fire && wr_use_cursor) cursor <= (cursor == LAST) ? '0 : cursor + AW'(1);
    end
  end

  // Registered pin drivers and scan pointer; the bus only moves on IDLE->SETUP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr       <= '0;
      chip      <= '0;
      hpdl_d    <= BLANK_CHAR;
      hpdl_a    <= 2'b11;
      hpdl_wr_n <= '1;
    end else begin
      if (take) begin
        hpdl_d <= buffer[ptr];
        hpdl_a <= ~ptr[1:0];
        chip   <= CW'(ptr >> 2);
      end
      if (advance) ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
      hpdl_wr_n <= (state_next == STROBE) ? ~(NUM_DISPLAYS'(1) << chip) : '1;
    end
  end

endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// tb_hpdl_display_ctrl: randomized and directed stimulus against a simple
// display-image model; a pin monitor decodes every strobe and scores it
// against the queue of character writes the model expects to see.
module tb_hpdl_display_ctrl;

  localparam int NUM_DISPLAYS = 4;
  localparam int NUM_CHARS    = 4 * NUM_DISPLAYS;
  localparam int AW           = $clog2(NUM_CHARS);
  localparam int T_SETUP      = 2;
  localparam int T_WR         = 4;
  localparam int T_HOLD       = 2;
  localparam int CHAR_COST    = 1 + T_SETUP + T_WR + T_HOLD;
  localparam int ALL_HIGH     = (1 << NUM_DISPLAYS) - 1;
  localparam int IDLE_BUDGET  = 2 * NUM_CHARS * CHAR_COST + 50;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic                    wr_valid = 1'b0;
  logic                    wr_ready;
  logic [AW-1:0]           wr_addr = '0;
  logic [7:0]              wr_data = '0;
  logic                    wr_use_cursor = 1'b0;
  logic                    clr = 1'b0;
  logic                    busy;
  logic [6:0]              hpdl_d;
  logic [1:0]              hpdl_a;
  logic [NUM_DISPLAYS-1:0] hpdl_wr_n;

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   buffer_m  [NUM_CHARS];
  int   display_m [NUM_CHARS];
  int   cursor_m = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  // 12 MHz-ish system clock.
  always #41 CLK = ~CLK;

  hpdl_display_ctrl #(
    .NUM_DISPLAYS(NUM_DISPLAYS),
    .T_SETUP     (T_SETUP),
    .T_WR        (T_WR),
    .T_HOLD      (T_HOLD),
    .REFRESH     (0),
    .FOLD_CASE   (1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_use_cursor(wr_use_cursor),
    .clr          (clr),
    .busy         (busy),
    .hpdl_d       (hpdl_d),
    .hpdl_a       (hpdl_a),
    .hpdl_wr_n    (hpdl_wr_n)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // What the display chip should show for a host byte.
  function automatic int refSanitize(input int c);
    int r;
    r = c;
    if (c >= 'h61 && c <= 'h7A) r = c - 32;
    if (r < 'h20 || r > 'h5F) r = 'h20;
    return r;
  endfunction

  // Every char becomes blank and must be rewritten once.
  task automatic modelBlankAll();
    for (int i = 0; i < NUM_CHARS; i++) begin
      buffer_m[i] = 'h20;
      exp_q.push_back('{i, 'h20});
    end
    cursor_m = 0;
  endtask

  task automatic applyStimulus(input int addr, input int data, input bit use_cursor);
    int idx;
    @(negedge CLK);
    wr_valid      = 1'b1;
    wr_addr       = AW'(addr);
    wr_data       = 8'(data);
    wr_use_cursor = use_cursor;
    #1 checkOutput("wr_ready", wr_ready, 1);
    idx = use_cursor ? cursor_m : addr;
    buffer_m[idx] = refSanitize(data);
    exp_q.push_back('{idx, buffer_m[idx]});
    if (use_cursor) cursor_m = (cursor_m + 1) % NUM_CHARS;
    @(posedge CLK);
    #1 wr_valid = 1'b0;
  endtask

  task automatic doClear(input bit with_write);
    @(negedge CLK);
    clr = 1'b1;
    if (with_write) begin
      wr_valid      = 1'b1;
      wr_data       = 8'h5A;
      wr_use_cursor = 1'b1;
    end
    #1 checkOutput("wr_ready_during_clr", wr_ready, 0);
    modelBlankAll();
    @(posedge CLK);
    #1;
    clr      = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < IDLE_BUDGET);
    checkOutput("busy_settles", busy, 0);
    cycles = n;
  endtask

  task automatic verifyImage();
    checkOutput("pending_strobes", exp_q.size(), 0);
    for (int i = 0; i < NUM_CHARS; i++)
      checkOutput($sformatf("display_char%0d", i), display_m[i], buffer_m[i]);
  endtask

  // Match a completed strobe with the oldest expected write to the same char.
  task automatic scoreStrobe(input int chip, input int a, input int d);
    int idx;
    int k;
    idx = chip * 4 + (3 - a);
    k = -1;
    foreach (exp_q[j]) if (k < 0 && exp_q[j].idx == idx) k = j;
    if (k < 0) begin
      checkOutput("unexpected_strobe_char", idx, -1);
    end else begin
      checkOutput($sformatf("strobe_data_char%0d", idx), d, exp_q[k].val);
      exp_q.delete(k);
    end
    display_m[idx] = d;
  endtask

  // Pin monitor: checks setup/strobe/hold timing and scores each strobe.
  initial begin : monitor
    int                      stable, low_cnt, hold_left, chip;
    bit                      in_strobe, hold_ok, bus_ok;
    logic [NUM_DISPLAYS-1:0] mask;
    logic [6:0]              sd, pd;
    logic [1:0]              sa, pa;
    stable = 0; low_cnt = 0; hold_left = 0; chip = 0;
    in_strobe = 0; hold_ok = 0; bus_ok = 0;
    mask = '1; sd = '0; pd = '0; sa = '0; pa = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        in_strobe = 0;
        hold_left = 0;
        stable    = 0;
        pd        = hpdl_d;
        pa        = hpdl_a;
        continue;
      end
      if (hpdl_wr_n == '1) stable = (hpdl_d == pd && hpdl_a == pa) ? stable + 1 : 1;
      if (in_strobe) begin
        if (hpdl_wr_n == mask) begin
          low_cnt++;
          if (hpdl_d != sd || hpdl_a != sa) bus_ok = 0;
        end else begin
          in_strobe = 0;
          checkOutput("strobe_width", low_cnt, T_WR);
          checkOutput("bus_during_strobe", bus_ok, 1);
          checkOutput("strobe_release", int'(hpdl_wr_n), ALL_HIGH);
          scoreStrobe(chip, int'(sa), int'(sd));
          hold_left = T_HOLD;
          hold_ok   = 1;
        end
      end else if (hold_left == 0 && hpdl_wr_n != '1) begin
        in_strobe = 1;
        low_cnt   = 1;
        bus_ok    = 1;
        mask      = hpdl_wr_n;
        sd        = hpdl_d;
        sa        = hpdl_a;
        chip      = 0;
        for (int i = 0; i < NUM_DISPLAYS; i++) if (!hpdl_wr_n[i]) chip = i;
        checkOutput("strobe_onehot", int'($onehot(~hpdl_wr_n)), 1);
        checkOutput("setup_time", int'(hpdl_d == pd && hpdl_a == pa && stable >= T_SETUP), 1);
      end
      if (hold_left > 0) begin
        if (hpdl_wr_n != '1 || hpdl_d != sd || hpdl_a != sa) hold_ok = 0;
        hold_left--;
        if (hold_left == 0) checkOutput("hold_time", hold_ok, 1);
      end
      pd = hpdl_d;
      pa = hpdl_a;
    end
  end

  // Main sequence: directed cases first, then random batches, then reset mid-strobe.
  initial begin : stimulus
    int cyc, n, uc, addr, data, idx, nw;
    bit used [NUM_CHARS];
    for (int i = 0; i < NUM_CHARS; i++) display_m[i] = -1;

    repeat (3) @(negedge CLK);
    #1;
    checkOutput("reset_wr_n", int'(hpdl_wr_n), ALL_HIGH);
    checkOutput("reset_d", int'(hpdl_d), 'h20);
    checkOutput("reset_a", int'(hpdl_a), 3);
    checkOutput("reset_wr_ready", int'(wr_ready), 1);
    checkOutput("reset_busy", int'(busy), 1);
    modelBlankAll();
    @(negedge CLK);
    #5 RST = 1'b0;
    waitIdle(cyc);
    checkOutput("power_up_blank_cycles", cyc, NUM_CHARS * CHAR_COST);
    verifyImage();

    applyStimulus(5, 'h61, 1'b0);
    waitIdle(cyc);
    verifyImage();

    for (int i = 0; i < 16; i++) applyStimulus(0, 'h41 + i, 1'b1);
    waitIdle(cyc);
    verifyImage();
    applyStimulus(0, 'h51, 1'b1);
    applyStimulus(0, 'h52, 1'b1);
    waitIdle(cyc);
    verifyImage();

    applyStimulus(9, 'h4D, 1'b0);
    applyStimulus(10, 'h4E, 1'b0);
    waitIdle(cyc);
    applyStimulus(9, 'h7E, 1'b0);
    applyStimulus(10, 'h10, 1'b0);
    waitIdle(cyc);
    verifyImage();

    doClear(1'b1);
    waitIdle(cyc);
    verifyImage();
    applyStimulus(0, 'h4B, 1'b1);
    waitIdle(cyc);
    verifyImage();

    applyStimulus(3, 'h41, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(hpdl_wr_n[0] == 1'b0 && hpdl_a == 2'b00) && n < 100);
    checkOutput("char3_strobe_seen", int'(hpdl_wr_n[0]), 0);
    applyStimulus(3, 'h58, 1'b0);
    waitIdle(cyc);
    verifyImage();

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < NUM_CHARS; i++) used[i] = 1'b0;
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        uc   = $urandom_range(0, 1);
        addr = $urandom_range(0, NUM_CHARS - 1);
        data = ($urandom_range(0, 1) == 1) ? $urandom_range('h20, 'h7F) : $urandom_range(0, 255);
        idx  = (uc != 0) ? cursor_m : addr;
        if (!used[idx]) begin
          used[idx] = 1'b1;
          applyStimulus(addr, data, uc != 0);
        end
        repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      waitIdle(cyc);
      verifyImage();
      if ($urandom_range(0, 7) == 0) begin
        doClear(1'b0);
        waitIdle(cyc);
        verifyImage();
      end
    end

    applyStimulus(7, 'h51, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (hpdl_wr_n[1] && n < 100);
    checkOutput("char7_strobe_seen", int'(hpdl_wr_n[1]), 0);
    #5 RST = 1'b1;
    #1;
    checkOutput("reset_mid_strobe_wr_n", int'(hpdl_wr_n), ALL_HIGH);
    checkOutput("reset_mid_strobe_d", int'(hpdl_d), 'h20);
    checkOutput("reset_mid_strobe_busy", int'(busy), 1);
    exp_q.delete();
    modelBlankAll();
    repeat (2) @(negedge CLK);
    #5 RST = 1'b0;
    waitIdle(cyc);
    checkOutput("post_reset_blank_cycles", cyc, NUM_CHARS * CHAR_COST);
    verifyImage();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop if something wedges beyond every bounded wait.
  initial begin : watchdog
    #8000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d compared, expected completion", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hpdl_display_ctrl.md
Name: hpdl_display_ctrl

Overview:
- Parametrised successor to the single-chip-group HPDL-1414 PMOD driver; drives NUM_DISPLAYS HPDL-1414 chips (4 chars each) from a shared 7-bit data bus and 2-bit address bus, with one WR_n strobe per chip.
- Holds a register shadow buffer with per-character dirty bits and writes only changed characters, with programmable setup, strobe and hold timing.
- Host side: valid/ready character write port with absolute or auto-increment cursor addressing, clear command, case folding.
- Sits between the UART/command logic and the PMOD pins.

Parameters:
NUM_DISPLAYS, 4, number of HPDL-1414 chips; NUM_CHARS = 4*NUM_DISPLAYS
T_SETUP, 2, CLK cycles addr/data stable before WR_n falls (>=1)
T_WR, 4, CLK cycles WR_n held low (>=1; 4 = 333 ns at 12 MHz)
T_HOLD, 2, CLK cycles addr/data held after WR_n rises (>=1)
REFRESH, 0, 1 = rewrite all characters continuously regardless of dirty bits
FOLD_CASE, 1, 1 = map 0x61-0x7A to 0x41-0x5A

Ports:
CLK  in  1  system clock, 12 MHz
RST  in  1  asynchronous active-high reset
wr_valid  in  1  host character write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  AW=clog2(NUM_CHARS)  char index; 0 = leftmost of chip 0
wr_data  in  8  ASCII character
wr_use_cursor  in  1  1 = write at internal cursor and ignore wr_addr
clr  in  1  single-cycle pulse: blank whole display, cursor to 0
busy  out  1  any dirty bit set, or writer not in IDLE
hpdl_d  out  7  shared data bus D6..D0
hpdl_a  out  2  shared address bus A1..A0
hpdl_wr_n  out  NUM_DISPLAYS  per-chip active-low write strobe

Behaviour:
- Reset (async, immediate): buffer = 0x20 in all chars; all dirty bits = 1; cursor = 0; scan ptr = 0; state IDLE; hpdl_wr_n = all 1; hpdl_d = 0x20; hpdl_a = 2'b11; wr_ready = 1. busy is therefore 1 from reset release, so the display is blanked after power-up. Reset mid-strobe forces WR_n high at once.
- Character sanitising: with FOLD_CASE=1, 0x61-0x7A has 0x20 subtracted. Any result outside 0x20-0x5F is stored as 0x20. The stored value is 7 bits.
- Host write: accepted in the cycle wr_valid && wr_ready. buffer[idx] and dirty[idx] are set on the next edge. idx = cursor if wr_use_cursor else wr_addr. wr_addr >= NUM_CHARS is accepted and dropped.
- Cursor: increments only on an accepted cursor write and wraps NUM_CHARS-1 -> 0.
- wr_ready = ~clr. When clr is high, clear takes precedence and any same-cycle write is not accepted. Clear sets all chars to 0x20, all dirty bits to 1 and cursor to 0 in one edge. A strobe already in progress completes normally.
- Writer FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  - IDLE: examine dirty[ptr], or any ptr when REFRESH=1.
    - If set: latch hpdl_d = buffer[ptr], hpdl_a = ~ptr[1:0] (position 0 = leftmost), chip = ptr[AW-1:2]; clear dirty[ptr]; go to SETUP.
    - Else: ptr++ with wrap.
  - SETUP: T_SETUP cycles, then go to STROBE.
  - STROBE: hpdl_wr_n[chip] = 0 for exactly T_WR cycles; all other strobes stay 1.
  - HOLD: T_HOLD cycles with WR_n high and bus unchanged; ptr++; go to IDLE.
- Cost per character: 1 + T_SETUP + T_WR + T_HOLD cycles (9 at defaults).
- Dirty-bit priority: a host write that sets dirty[i] in the same cycle IDLE clears it wins (set), so the char is rewritten on a later pass.
- Same-char update: a host write to the char currently in SETUP/STROBE/HOLD does not change the latched bus. The new value is written on the next visit.
- hpdl_d and hpdl_a change only on IDLE->SETUP. All pin outputs are registered, so there are no glitches.
- busy = (|dirty) | (state != IDLE). With REFRESH=1, busy = 1 always.

Decomposition:
- Shared package hpdl_pkg: constants CHARS_PER_DISPLAY=4, BLANK_CHAR=7'h20, CHAR_MIN=8'h20, CHAR_MAX=8'h5F; FSM state typedef {IDLE, SETUP, STROBE, HOLD}; function hpdl_sanitize(8b)->7b.
- One sub-module, hpdl_strobe_timer: loadable down-counter sized to max(T_SETUP, T_WR, T_HOLD), with a done flag; it sequences the three timed phases.

Test Plan:
- Reset release, defaults → 16 strobes, one per char, every hpdl_d = 0x20. Each WR_n low exactly 4 cycles, with addr/data stable 2 cycles before and 2 after. busy falls after 144 cycles.
- Idle, write wr_addr=5, wr_data=0x61 → exactly one strobe: hpdl_wr_n[1] low, hpdl_a = 2'b10, hpdl_d = 0x41. No other strobe follows.
- 18 cursor writes "ABCDEFGHIJKLMNOPQR" → chars 0-15 = A..P, then chars 0,1 = Q,R (wrap). The final strobe for char 0 carries 0x51.
- wr_data=0x7E and 0x10 → stored and driven as 0x20.
- clr asserted in the same cycle as a wr_valid of 'Z' → wr_ready = 0 and the write is dropped; all 16 chars rewritten to 0x20; the next cursor write lands at index 0.
- Write char 3 = 'X' during char 3's STROBE (previous 'A') → the bus keeps 0x41 for that strobe, then a second strobe drives 0x58. RST asserted during STROBE → WR_n high in the same cycle, and all 16 chars are rewritten after release.
